// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - byte handshake between the telemetry framer and uart_send
interface uart_frame_tx_if;
    logic       uart_en;
    logic [7:0] uart_din;
    logic       uart_tx_busy;

    modport master (output uart_en, output uart_din, input uart_tx_busy);
    modport slave  (input uart_en, input uart_din, output uart_tx_busy);
endinterface

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - telemetry framer (HEADER,TYPE,h,m,s,temp[,CHK]); CHK byte enabled by UART_FRAME_CHK_EN
module uart_frame_tx #(
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         BUSY_TIMEOUT = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             frame_req,
    input  logic [7:0]       hour,
    input  logic [7:0]       min,
    input  logic [7:0]       sec,
    input  logic [7:0]       temp,
    input  logic             alarm_temp,
    input  logic             alarm_clock,
    uart_frame_tx_if.master  uart,
    output logic             frame_busy,
    output logic             frame_done,
    output logic [7:0]       frames_sent
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;

`ifdef UART_FRAME_CHK_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif
    localparam logic [7:0] TO_LIM = 8'(BUSY_TIMEOUT);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic [7:0] sent_q, sent_d;
    logic [7:0] din_q, din_d;
    logic [7:0] type_q, hour_q, min_q, sec_q, temp_q;
    logic       load;
    logic       en;
    logic       done;
    logic [7:0] cur_byte;
    logic [7:0] type_now;

    assign type_now = alarm_temp ? 8'h02 : (alarm_clock ? 8'h03 : 8'h01);

    always_comb begin
        cur_byte = HEADER;
        case (idx_q)
            3'd1:    cur_byte = type_q;
            3'd2:    cur_byte = hour_q;
            3'd3:    cur_byte = min_q;
            3'd4:    cur_byte = sec_q;
            3'd5:    cur_byte = temp_q;
`ifdef UART_FRAME_CHK_EN
            3'd6:    cur_byte = type_q + hour_q + min_q + sec_q + temp_q;
`endif
            default: cur_byte = HEADER;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sent_d  = sent_q;
        din_d   = din_q;
        load    = 1'b0;
        en      = 1'b0;
        done    = 1'b0;

        // Any request outside IDLE (including the NEXT->IDLE cycle) is remembered once.
        if (frame_req && (state_q != IDLE))
            pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_req || pend_q) begin
                    load    = 1'b1;
                    pend_d  = 1'b0;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Hold off while uart_send is still finishing an earlier byte.
                if (!uart.uart_tx_busy) begin
                    en      = 1'b1;
                    din_d   = cur_byte;
                    cnt_d   = 8'd0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (uart.uart_tx_busy)
                    state_d = WAIT_LO;
                else if (cnt_q == TO_LIM)
                    state_d = NEXT;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            WAIT_LO: begin
                if (!uart.uart_tx_busy)
                    state_d = NEXT;
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    done    = 1'b1;
                    sent_d  = sent_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
            sent_q  <= 8'd0;
            din_q   <= 8'h00;
            type_q  <= 8'h00;
            hour_q  <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            temp_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sent_q  <= sent_d;
            din_q   <= din_d;
            if (load) begin
                type_q <= type_now;
                hour_q <= hour;
                min_q  <= min;
                sec_q  <= sec;
                temp_q <= temp;
            end
        end
    end

    // The byte is presented combinationally in SEND so it is valid alongside uart_en.
    assign uart.uart_en  = en;
    assign uart.uart_din = (state_q == SEND) ? cur_byte : din_q;
    assign frame_busy    = (state_q != IDLE) && !done;
    assign frame_done    = done;
    assign frames_sent   = sent_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - directed self-checking bench for uart_frame_tx
module tb_uart_frame_tx;

`ifdef UART_FRAME_CHK_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       frame_req = 1'b0;
    logic [7:0] hour = 8'd0, min = 8'd0, sec = 8'd0, temp = 8'd0;
    logic       alarm_temp = 1'b0, alarm_clock = 1'b0;
    logic       frame_busy, frame_done;
    logic [7:0] frames_sent;

    uart_frame_tx_if bus ();

    uart_frame_tx #(.HEADER(8'hA5), .BUSY_TIMEOUT(16)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .frame_req   (frame_req),
        .hour        (hour),
        .min         (min),
        .sec         (sec),
        .temp        (temp),
        .alarm_temp  (alarm_temp),
        .alarm_clock (alarm_clock),
        .uart        (bus),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_cnt = 0;
    bit stuck = 1'b0;
    int done_cnt = 0;
    int overlap = 0;
    logic [7:0] q_byte[$];
    int         q_cyc[$];
    int         exp_sent = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge sys_clk) cyc++;

    // uart_send model: busy for 10 cycles after each strobe, or never when stuck.
    initial bus.uart_tx_busy = 1'b0;
    always @(negedge sys_clk) begin
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) bus.uart_tx_busy = 1'b0;
        end
        if (bus.uart_en === 1'b1) begin
            q_byte.push_back(bus.uart_din);
            q_cyc.push_back(cyc);
            if (!stuck) begin
                busy_cnt = 10;
                bus.uart_tx_busy = 1'b1;
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            if (frame_busy !== 1'b0) overlap++;
        end
    end

    task automatic send_req(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic [7:0] t, input logic at, input logic ac,
                            input bit chk_start, input string tag);
        @(negedge sys_clk);
        hour = h; min = m; sec = s; temp = t; alarm_temp = at; alarm_clock = ac;
        frame_req = 1'b1;
        @(negedge sys_clk);
        frame_req = 1'b0;
        if (chk_start) begin
            check({tag, "_busy_n1"}, int'(frame_busy), 1);
            check({tag, "_en_n1"}, int'(bus.uart_en), 1);
        end
    endtask

    task automatic wait_done(input int target, input string tag);
        int k;
        k = 0;
        while (done_cnt < target && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        if (done_cnt < target) check({tag, "_done_timeout"}, done_cnt, target);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k;
        k = 0;
        while (q_byte.size() < n && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        if (q_byte.size() < n) check({tag, "_byte_timeout"}, q_byte.size(), n);
    endtask

    task automatic check_frame(input int base, input logic [7:0] ty, input logic [7:0] h,
                               input logic [7:0] m, input logic [7:0] s, input logic [7:0] t,
                               input logic [7:0] ck, input string tag);
        logic [7:0] e[7];
        e[0] = 8'hA5; e[1] = ty; e[2] = h; e[3] = m; e[4] = s; e[5] = t; e[6] = ck;
        for (int i = 0; i < NB; i++) begin
            if (base + i < q_byte.size())
                check($sformatf("%s_b%0d", tag, i), int'(q_byte[base + i]), int'(e[i]));
            else
                check($sformatf("%s_b%0d_missing", tag, i), q_byte.size(), base + i + 1);
        end
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge sys_clk);
        check("rst_en", int'(bus.uart_en), 0);
        check("rst_din", int'(bus.uart_din), 0);
        check("rst_busy", int'(frame_busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_sent", int'(frames_sent), 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Plain frame: 1+0C+22+38+19 = 80
        q_byte.delete(); q_cyc.delete();
        send_req(8'd12, 8'd34, 8'd56, 8'h19, 1'b0, 1'b0, 1'b1, "plain");
        wait_done(1, "plain");
        exp_sent++;
        repeat (3) @(negedge sys_clk);
        check("plain_nbytes", q_byte.size(), NB);
        check_frame(0, 8'h01, 8'h0C, 8'h22, 8'h38, 8'h19, 8'h80, "plain");
        check("plain_sent", int'(frames_sent), exp_sent);

        // Both alarms: temp alarm wins, TYPE 02, CHK 81
        q_byte.delete(); q_cyc.delete();
        send_req(8'd12, 8'd34, 8'd56, 8'h19, 1'b1, 1'b1, 1'b1, "talm");
        wait_done(2, "talm");
        exp_sent++;
        repeat (3) @(negedge sys_clk);
        check_frame(0, 8'h02, 8'h0C, 8'h22, 8'h38, 8'h19, 8'h81, "talm");
        check("talm_sent", int'(frames_sent), exp_sent);

        // Clock alarm only: TYPE 03, CHK 82
        q_byte.delete(); q_cyc.delete();
        send_req(8'd12, 8'd34, 8'd56, 8'h19, 1'b0, 1'b1, 1'b1, "calm");
        wait_done(3, "calm");
        exp_sent++;
        repeat (3) @(negedge sys_clk);
        check_frame(0, 8'h03, 8'h0C, 8'h22, 8'h38, 8'h19, 8'h82, "calm");
        check("calm_sent", int'(frames_sent), exp_sent);

        // Pending: second request during byte 3, third during byte 5 is dropped
        q_byte.delete(); q_cyc.delete();
        d0 = done_cnt;
        send_req(8'd12, 8'd34, 8'd56, 8'h19, 1'b0, 1'b0, 1'b1, "pend");
        wait_bytes(4, "pend3");
        send_req(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0, "pend2");
        wait_bytes(6, "pend5");
        send_req(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0, "pend3");
        wait_done(d0 + 2, "pend");
        repeat (200) @(negedge sys_clk);
        exp_sent += 2;
        check("pend_frames", done_cnt - d0, 2);
        check("pend_nbytes", q_byte.size(), 2 * NB);
        check_frame(0, 8'h01, 8'h0C, 8'h22, 8'h38, 8'h19, 8'h80, "pend_f1");
        check_frame(NB, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B, "pend_f2");
        check("pend_sent", int'(frames_sent), exp_sent);

        // Timeout path: busy never rises, strobes 19 cycles apart
        stuck = 1'b1;
        q_byte.delete(); q_cyc.delete();
        d0 = done_cnt;
        send_req(8'd12, 8'd34, 8'd56, 8'h19, 1'b0, 1'b0, 1'b1, "tmo");
        wait_done(d0 + 1, "tmo");
        exp_sent++;
        repeat (3) @(negedge sys_clk);
        check("tmo_nbytes", q_byte.size(), NB);
        for (int i = 1; i < NB && i < q_cyc.size(); i++)
            check($sformatf("tmo_gap%0d", i), q_cyc[i] - q_cyc[i-1], 19);
        check_frame(0, 8'h01, 8'h0C, 8'h22, 8'h38, 8'h19, 8'h80, "tmo");
        check("tmo_sent", int'(frames_sent), exp_sent);
        stuck = 1'b0;

        // Reset during byte 4 abandons the frame
        q_byte.delete(); q_cyc.delete();
        send_req(8'd12, 8'd34, 8'd56, 8'h19, 1'b0, 1'b0, 1'b1, "rst");
        wait_bytes(5, "rst4");
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check("mrst_en", int'(bus.uart_en), 0);
        check("mrst_din", int'(bus.uart_din), 0);
        check("mrst_busy", int'(frame_busy), 0);
        check("mrst_sent", int'(frames_sent), 0);
        @(negedge sys_clk);
        check("mrst_done", int'(frame_done), 0);
        sys_rst_n = 1'b1;
        exp_sent = 0;
        repeat (20) @(negedge sys_clk);
        q_byte.delete(); q_cyc.delete();
        d0 = done_cnt;
        send_req(8'd12, 8'd34, 8'd56, 8'h19, 1'b0, 1'b0, 1'b1, "post");
        wait_done(d0 + 1, "post");
        exp_sent++;
        repeat (3) @(negedge sys_clk);
        check("post_nbytes", q_byte.size(), NB);
        check_frame(0, 8'h01, 8'h0C, 8'h22, 8'h38, 8'h19, 8'h80, "post");
        check("post_sent", int'(frames_sent), exp_sent);

        check("done_busy_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Telemetry framer between the clock/temperature/alarm logic and `uart_send`. On each request it snapshots the current time, the DS18B20 temperature byte and the alarm flags. It then streams a fixed-length byte frame to `uart_send` using the `uart_en`/`uart_tx_busy` handshake, so the host receives timestamped, typed, checksummed records instead of bare bytes.

## Interface
- `HEADER`, 8'hA5, first byte of every frame
- `BUSY_TIMEOUT`, 16, cycles to wait for `uart_tx_busy` to rise after a `uart_en` pulse before treating the byte as sent (range 2..255)
- `sys_clk` input 1: system clock (12 MHz)
- `sys_rst_n` input 1: asynchronous active-low reset
- `frame_req` input 1: one-cycle request pulse (driven from the 1 s tick)
- `hour` input 8: binary hour, 0..23
- `min` input 8: binary minute, 0..59
- `sec` input 8: binary second, 0..59
- `temp` input 8: integer °C, `{1'b0, ds18b20_data[10:4]}`
- `alarm_temp` input 1: over-temperature flag
- `alarm_clock` input 1: clock alarm active
- `uart_tx_busy` input 1: busy flag from `uart_send`
- `uart_en` output 1: one-cycle send strobe to `uart_send`
- `uart_din` output 8: byte to `uart_send`
- `frame_busy` output 1: high from frame start until the last byte completes
- `frame_done` output 1: one-cycle pulse after the last byte of a frame
- `frames_sent` output 8: count of completed frames, wraps 255→0

## Operation
- Frame bytes in order: `HEADER`, TYPE, hour, min, sec, temp, CHK.
- TYPE priority:
  - 8'h02 if `alarm_temp`
  - otherwise 8'h03 if `alarm_clock`
  - otherwise 8'h01
- CHK is the 8-bit sum, mod 256, of TYPE, hour, min, sec and temp. `HEADER` is excluded.
- Snapshot: all data inputs and the computed TYPE are registered in the cycle the request is accepted. Later input changes do not affect the frame in flight.
- FSM states:
  - IDLE: accept `frame_req` or a pending request. Load the snapshot, set byte index 0, go to SEND.
  - SEND: drive `uart_din` with byte[index] and assert `uart_en` for exactly one cycle. Go to WAIT_HI.
  - WAIT_HI: go to WAIT_LO when `uart_tx_busy`=1. If the timeout counter reaches `BUSY_TIMEOUT`, go to NEXT.
  - WAIT_LO: go to NEXT when `uart_tx_busy`=0.
  - NEXT: if index is the last byte, pulse `frame_done`, increment `frames_sent` and go to IDLE. Otherwise increment index and go to SEND.
- `uart_din` holds its value from SEND until the next SEND.
- Pending request: a `frame_req` arriving while not in IDLE sets a one-deep pending flag. Further requests while pending is set are dropped.
  - The pending request starts on the first IDLE cycle and captures inputs at that cycle.
- `frame_req` in the same cycle as the NEXT→IDLE transition sets pending. It is never lost.
- `frame_req` while `uart_tx_busy` is already high in IDLE is still accepted. SEND waits in place until `uart_tx_busy`=0 before pulsing `uart_en`.

## Timing
- Reset values: `uart_en`=0, `uart_din`=8'h00, `frame_busy`=0, `frame_done`=0, `frames_sent`=0, FSM=IDLE, pending flag=0.
- A `frame_req` at cycle N (IDLE) gives:
  - `frame_busy`=1 and SEND at N+1
  - first `uart_en` pulse at N+1
- Between bytes, the next `uart_en` is asserted 2 cycles after `uart_tx_busy` falls (WAIT_LO→NEXT→SEND).
- `frame_done` fires in the cycle after the last byte's busy falls. `frame_busy` drops in the same cycle.
- Timeout path: with `uart_tx_busy` stuck at 0, each byte takes `BUSY_TIMEOUT`+3 cycles.
- Reset asserted mid-frame returns everything to reset values immediately. The partial frame is abandoned and not counted.

## Configuration
- `UART_FRAME_CHK_EN` defined: 7-byte frame including CHK.
- Not defined: 6-byte frame. CHK logic is removed, and NEXT terminates after temp (index 5).

## Test plan
- `UART_FRAME_CHK_EN`; hour=12, min=34, sec=56, temp=8'h19, no alarms; `frame_req`; `uart_tx_busy` model high for 10 cycles per byte -> bytes A5 01 0C 22 38 19 80, one `frame_done`, `frames_sent`=1.
- Same data with `alarm_temp`=1 and `alarm_clock`=1 -> TYPE 02, CHK 81. Repeat with only `alarm_clock`=1 -> TYPE 03, CHK 82.
- Second `frame_req` during byte 3, third during byte 5 -> exactly two frames. The second frame carries the inputs present at its start, and `frames_sent`=2.
- `uart_tx_busy` tied 0, `BUSY_TIMEOUT`=16 -> 7 `uart_en` pulses spaced 19 cycles apart, then `frame_done`.
- `sys_rst_n` low during byte 4 -> all outputs return to reset values. A new request sends a complete frame starting with A5.
- `UART_FRAME_CHK_EN` undefined, same data as the first scenario -> bytes A5 01 0C 22 38 19 only, then `frame_done`.
